// File: rtl/cmult_pkg.sv
// cmult_pkg: shared latency constant and round/saturate helpers for cmult_stream
package cmult_pkg;
  localparam int LATENCY = 6;
  typedef struct packed {
    logic signed [63:0] v;
    logic               ovf;
  } sat_t;
  function automatic int full_width(input int a_w, input int b_w);
    return a_w + b_w + 1;
  endfunction
  // round-half-up: bias by half an LSB of the kept part, then arithmetic shift
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] x, input int sh);
    return (sh > 0) ? (x + (64'sd1 <<< (sh - 1))) >>> sh : x;
  endfunction
  function automatic sat_t saturate(input logic signed [63:0] x, input int ow);
    logic signed [63:0] hi, lo;
    sat_t s;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) s = '{v: hi, ovf: 1'b1};
    else if (x < lo) s = '{v: lo, ovf: 1'b1};
    else s = '{v: x, ovf: 1'b0};
    return s;
  endfunction
endpackage

// File: rtl/cmult_stream_if.sv
// cmult_stream_if: operand/result stream bundle with valid/ready handshakes
//   slave  : the multiplier's view (operands in, results out)
//   master : the producer/consumer view
interface cmult_stream_if #(
  parameter int A_WIDTH    = 16,
  parameter int B_WIDTH    = 18,
  parameter int OUT_WIDTH  = 16,
  parameter int USER_WIDTH = 8
);
  logic signed [A_WIDTH-1:0]   ar_i, ai_i;
  logic signed [B_WIDTH-1:0]   br_i, bi_i;
  logic                        conj_i;
  logic [USER_WIDTH-1:0]       user_i;
  logic                        s_valid_i, s_ready_o;
  logic signed [OUT_WIDTH-1:0] pr_o, pi_o;
  logic [USER_WIDTH-1:0]       user_o;
  logic                        ovf_o;
  logic                        m_valid_o, m_ready_i;
  modport slave (
    input  ar_i, ai_i, br_i, bi_i, conj_i, user_i, s_valid_i, m_ready_i,
    output s_ready_o, pr_o, pi_o, user_o, ovf_o, m_valid_o
  );
  modport master (
    output ar_i, ai_i, br_i, bi_i, conj_i, user_i, s_valid_i, m_ready_i,
    input  s_ready_o, pr_o, pi_o, user_o, ovf_o, m_valid_o
  );
endinterface

// File: rtl/cmult_round_sat.sv
// cmult_round_sat: two-stage round-half-up shift then saturate of one component
//   clk_i/rst_i : clock, sync active-high reset (clears output register only)
//   i_en        : pipeline advance
//   i_x         : full-precision signed input
//   o_y/o_ovf   : registered saturated result and clamp flag
module cmult_round_sat
  import cmult_pkg::*;
#(
  parameter int IN_WIDTH  = 35,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 15
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        i_en,
  input  logic signed [IN_WIDTH-1:0]  i_x,
  output logic signed [OUT_WIDTH-1:0] o_y,
  output logic                        o_ovf
);
  // one extra bit holds the rounding carry before the shift drops SHIFT bits
  localparam int RW = IN_WIDTH + 1 - SHIFT;
  logic signed [RW-1:0] r_rnd;
  sat_t w_sat;
  assign w_sat = saturate(64'(r_rnd), OUT_WIDTH);
  always_ff @(posedge clk_i)
    if (i_en) r_rnd <= RW'(round_shift(64'(i_x), SHIFT));
  always_ff @(posedge clk_i)
    if (rst_i) begin
      o_y   <= '0;
      o_ovf <= 1'b0;
    end else if (i_en) begin
      o_y   <= OUT_WIDTH'(w_sat.v);
      o_ovf <= w_sat.ovf;
    end
endmodule

// File: rtl/cmult_stream.sv
// cmult_stream: 6-stage streaming complex multiplier, A*B or A*conj(B), rounded and saturated
//   clk_i : clock
//   rst_i : sync active-high reset, flushes all in-flight samples
//   bus   : operands/conj/user + s_valid/s_ready in; pr/pi/user/ovf + m_valid/m_ready out
module cmult_stream
  import cmult_pkg::*;
#(
  parameter int A_WIDTH    = 16,
  parameter int B_WIDTH    = 18,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 15,
  parameter int USER_WIDTH = 8
) (
  input logic           clk_i,
  input logic           rst_i,
  cmult_stream_if.slave bus
);
  localparam int FW  = full_width(A_WIDTH, B_WIDTH);
  localparam int PW  = FW + 1;
  localparam int AW1 = A_WIDTH + 1;
  localparam int BW1 = B_WIDTH + 1;
  localparam int BW2 = B_WIDTH + 2;
  if (SHIFT + OUT_WIDTH > FW || SHIFT >= FW || FW >= 64) begin : g_bad_params
    $error("cmult_stream: parameters need SHIFT+OUT_WIDTH <= FW, SHIFT < FW and FW < 64");
  end
  logic                    w_en, w_ovf_r, w_ovf_i;
  logic [LATENCY-1:0]      r_v;
  logic [USER_WIDTH-1:0]   r_user [LATENCY-1];
  logic [USER_WIDTH-1:0]   r_user_o;
  logic signed [A_WIDTH-1:0] r1_ar, r1_ai, r2_ar, r2_ai;
  logic signed [B_WIDTH-1:0] r1_br, r1_bi;
  logic                    r1_conj;
  logic signed [BW1-1:0]   w_bn, r2_bn;
  logic signed [AW1-1:0]   r2_d;
  logic signed [BW2-1:0]   r2_sr, r2_sp;
  logic signed [PW-1:0]    r3_mc, r3_mr, r3_mi;
  logic signed [FW-1:0]    r4_fr, r4_fi;
  // the whole pipeline moves together; it only freezes when a result is waiting
  assign w_en          = bus.m_ready_i | ~r_v[LATENCY-1];
  assign bus.s_ready_o = w_en;
  assign bus.m_valid_o = r_v[LATENCY-1];
  assign bus.user_o    = r_user_o;
  assign bus.ovf_o     = w_ovf_r | w_ovf_i;
  // conjugation is folded in by negating bi once; the rest of the datapath is mode-free
  assign w_bn = r1_conj ? -BW1'(r1_bi) : BW1'(r1_bi);
  // pr = ar*(br-bn) + bn*(ar-ai), pi = ai*(br+bn) + bn*(ar-ai)
  always_ff @(posedge clk_i)
    if (w_en) begin
      r1_ar     <= bus.ar_i;
      r1_ai     <= bus.ai_i;
      r1_br     <= bus.br_i;
      r1_bi     <= bus.bi_i;
      r1_conj   <= bus.conj_i;
      r2_ar     <= r1_ar;
      r2_ai     <= r1_ai;
      r2_bn     <= w_bn;
      r2_d      <= AW1'(r1_ar) - AW1'(r1_ai);
      r2_sr     <= BW2'(r1_br) - BW2'(w_bn);
      r2_sp     <= BW2'(r1_br) + BW2'(w_bn);
      r3_mc     <= PW'(r2_d) * PW'(r2_bn);
      r3_mr     <= PW'(r2_ar) * PW'(r2_sr);
      r3_mi     <= PW'(r2_ai) * PW'(r2_sp);
      r4_fr     <= FW'(r3_mr + r3_mc);
      r4_fi     <= FW'(r3_mi + r3_mc);
      r_user[0] <= bus.user_i;
      for (int k = 1; k < LATENCY - 1; k++) r_user[k] <= r_user[k-1];
    end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_v      <= '0;
      r_user_o <= '0;
    end else if (w_en) begin
      r_v      <= {r_v[LATENCY-2:0], bus.s_valid_i};
      r_user_o <= r_user[LATENCY-2];
    end
  cmult_round_sat #(.IN_WIDTH(FW), .OUT_WIDTH(OUT_WIDTH), .SHIFT(SHIFT)) u_rs_r (
    .clk_i(clk_i), .rst_i(rst_i), .i_en(w_en), .i_x(r4_fr), .o_y(bus.pr_o), .o_ovf(w_ovf_r)
  );
  cmult_round_sat #(.IN_WIDTH(FW), .OUT_WIDTH(OUT_WIDTH), .SHIFT(SHIFT)) u_rs_i (
    .clk_i(clk_i), .rst_i(rst_i), .i_en(w_en), .i_x(r4_fi), .o_y(bus.pi_o), .o_ovf(w_ovf_i)
  );
endmodule
